// File: rtl/trace_pkg.sv
// Shared definitions for the commit trace buffer: ebreak encoding, FSM states, entry layout.
// Entry layout widens to carry a cycle stamp when TRACE_TIMESTAMP_EN is defined.
package trace_pkg;

    localparam logic [31:0] EBREAK_INST = 32'h0010_0073;

    typedef enum logic [1:0] {
        TR_RUN    = 2'd0,
        TR_DRAIN  = 2'd1,
        TR_HALTED = 2'd2
    } tr_state_t;

`ifdef TRACE_TIMESTAMP_EN
    localparam int ENTRY_W = 224;

    typedef struct packed {
        logic [63:0] cycle;
        logic [63:0] pc;
        logic [31:0] inst;
        logic [63:0] seq;
    } trace_entry_t;
`else
    localparam int ENTRY_W = 160;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [63:0] seq;
    } trace_entry_t;
`endif

endpackage

// File: rtl/commit_trace_buffer_if.sv
// Trace drain handshake: the buffer (master) presents the head entry, the consumer (slave) accepts it.
// trace_cycle_o exists only when TRACE_TIMESTAMP_EN is defined.
interface commit_trace_buffer_if;

    logic        trace_valid_o;
    logic        trace_ready_i;
    logic [63:0] trace_pc_o;
    logic [31:0] trace_inst_o;
    logic [63:0] trace_seq_o;
`ifdef TRACE_TIMESTAMP_EN
    logic [63:0] trace_cycle_o;
`endif

    modport master (
        input  trace_ready_i,
        output trace_valid_o,
        output trace_pc_o,
        output trace_inst_o,
`ifdef TRACE_TIMESTAMP_EN
        output trace_cycle_o,
`endif
        output trace_seq_o
    );

    modport slave (
        output trace_ready_i,
        input  trace_valid_o,
        input  trace_pc_o,
        input  trace_inst_o,
`ifdef TRACE_TIMESTAMP_EN
        input  trace_cycle_o,
`endif
        input  trace_seq_o
    );

endinterface

// File: rtl/trace_fifo.sv
// Power-of-two FIFO with wrap-bit pointers; head word is read combinationally so a pushed entry
// is visible the cycle after the push. A push into a full FIFO is accepted only alongside a pop.
module trace_fifo #(
    parameter int  DEPTH = 16,
    parameter int  WIDTH = 160,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   level
);

    localparam logic [PTR_W:0] PTR_ONE = (PTR_W + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wptr_reg;
    logic [PTR_W:0]   rptr_reg;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wptr_reg == rptr_reg);
    assign full    = (wptr_reg[PTR_W] != rptr_reg[PTR_W]) &&
                     (wptr_reg[PTR_W-1:0] == rptr_reg[PTR_W-1:0]);
    assign level   = wptr_reg - rptr_reg;
    assign do_pop  = pop && !empty;
    // When full, the slot being written is the one being popped this cycle.
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wptr_reg <= '0;
            rptr_reg <= '0;
        end else begin
            if (do_push) wptr_reg <= wptr_reg + PTR_ONE;
            if (do_pop)  rptr_reg <= rptr_reg + PTR_ONE;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wptr_reg[PTR_W-1:0]] <= wdata;
    end

    assign rdata = mem[rptr_reg[PTR_W-1:0]];

endmodule

// File: rtl/commit_trace_buffer.sv
// Captures each CPU retirement into a trace FIFO, drains it over valid/ready, halts after ebreak drains.
// Define TRACE_TIMESTAMP_EN to stamp every entry with a free-running cycle counter.
module commit_trace_buffer
    import trace_pkg::*;
#(
    parameter int          DEPTH  = 16,
    parameter logic [31:0] EBREAK = EBREAK_INST,
    localparam int         PTR_W  = $clog2(DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [63:0]           pc_i,
    input  logic [31:0]           inst_i,
    input  logic [63:0]           nr_insts_i,
    commit_trace_buffer_if.master trace,
    output logic [PTR_W:0]        level_o,
    output logic [31:0]           dropped_o,
    output logic                  skip_err_o,
    output logic                  halted_o
);

    logic [63:0]        prev_cnt_reg;
    logic [31:0]        dropped_reg;
    logic               skip_err_reg;
    tr_state_t          state_reg;
    tr_state_t          state_next;
    logic               retire;
    logic               pop;
    logic               full;
    logic               empty;
    logic [63:0]        delta;
    logic [ENTRY_W-1:0] wdata;
    logic [ENTRY_W-1:0] rdata;
    trace_entry_t       new_entry;
    trace_entry_t       head_entry;
`ifdef TRACE_TIMESTAMP_EN
    logic [63:0]        cycle_reg;
`endif

    // Counter wrap from all-ones to zero falls out of the modulo subtraction as delta 1.
    assign retire = (nr_insts_i != prev_cnt_reg) && (state_reg == TR_RUN);
    assign delta  = nr_insts_i - prev_cnt_reg;
    assign pop    = !empty && trace.trace_ready_i;

    always_comb begin
        new_entry       = '0;
        new_entry.pc    = pc_i;
        new_entry.inst  = inst_i;
        new_entry.seq   = nr_insts_i;
`ifdef TRACE_TIMESTAMP_EN
        new_entry.cycle = cycle_reg;
`endif
    end

    assign wdata = new_entry;

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (retire),
        .wdata (wdata),
        .pop   (pop),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .level (level_o)
    );

    // Head is forced to zero while empty so stale storage never leaks onto the outputs.
    assign head_entry          = empty ? '0 : trace_entry_t'(rdata);
    assign trace.trace_valid_o = !empty;
    assign trace.trace_pc_o    = head_entry.pc;
    assign trace.trace_inst_o  = head_entry.inst;
    assign trace.trace_seq_o   = head_entry.seq;
`ifdef TRACE_TIMESTAMP_EN
    assign trace.trace_cycle_o = head_entry.cycle;
`endif

    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            TR_RUN:    if (retire && inst_i == EBREAK) state_next = TR_DRAIN;
            // Halt as soon as the final pop empties the FIFO.
            TR_DRAIN:  if (empty || (pop && level_o == (PTR_W + 1)'(1))) state_next = TR_HALTED;
            TR_HALTED: state_next = TR_HALTED;
            default:   state_next = TR_RUN;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prev_cnt_reg <= '0;
            dropped_reg  <= '0;
            skip_err_reg <= 1'b0;
            state_reg    <= TR_RUN;
        end else begin
            prev_cnt_reg <= nr_insts_i;
            state_reg    <= state_next;
            if (retire && delta > 64'd1) skip_err_reg <= 1'b1;
            if (retire && full && !pop && dropped_reg != 32'hFFFF_FFFF)
                dropped_reg <= dropped_reg + 32'd1;
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) cycle_reg <= '0;
        else       cycle_reg <= cycle_reg + 64'd1;
    end
`endif

    assign dropped_o  = dropped_reg;
    assign skip_err_o = skip_err_reg;
    assign halted_o   = (state_reg == TR_HALTED);

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Self-checking bench for commit_trace_buffer: directed scenarios plus random retirement traffic,
// all compared each cycle against a queue-based reference model.
module tb_commit_trace_buffer;

    localparam int          DEPTH      = 16;
    localparam logic [31:0] EBREAK_ENC = 32'h0010_0073;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [63:0] seq;
        logic [63:0] cyc;
    } ent_t;

    logic                    clock = 1'b0;
    logic                    reset = 1'b0;
    logic [63:0]             pc_i = '0;
    logic [31:0]             inst_i = '0;
    logic [63:0]             nr_insts_i = '0;
    logic [$clog2(DEPTH):0]  level_o;
    logic [31:0]             dropped_o;
    logic                    skip_err_o;
    logic                    halted_o;

    commit_trace_buffer_if tb_if ();

    commit_trace_buffer #(.DEPTH(DEPTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .pc_i       (pc_i),
        .inst_i     (inst_i),
        .nr_insts_i (nr_insts_i),
        .trace      (tb_if),
        .level_o    (level_o),
        .dropped_o  (dropped_o),
        .skip_err_o (skip_err_o),
        .halted_o   (halted_o)
    );

    always #5 clock = ~clock;

    // Reference model state
    ent_t        q[$];
    logic [63:0] m_prev;
    int          m_mode;     // 0 run, 1 draining, 2 halted
    logic [31:0] m_dropped;
    bit          m_skip;
    logic [63:0] m_cyc;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        bit v;
        v = (q.size() != 0);
        check_val("valid",   64'(tb_if.trace_valid_o), 64'(v));
        check_val("pc",      tb_if.trace_pc_o,   v ? q[0].pc : 64'd0);
        check_val("inst",    64'(tb_if.trace_inst_o), v ? 64'(q[0].inst) : 64'd0);
        check_val("seq",     tb_if.trace_seq_o,  v ? q[0].seq : 64'd0);
`ifdef TRACE_TIMESTAMP_EN
        check_val("cycle",   tb_if.trace_cycle_o, v ? q[0].cyc : 64'd0);
`endif
        check_val("level",   64'(level_o),    64'(q.size()));
        check_val("dropped", 64'(dropped_o),  64'(m_dropped));
        check_val("skip",    64'(skip_err_o), 64'(m_skip));
        check_val("halted",  64'(halted_o),   64'(m_mode == 2));
    endtask

    // One clock edge of the reference behaviour, using the inputs currently applied.
    task automatic model_step();
        bit   retire;
        int   old_mode;
        ent_t e;
        retire   = (nr_insts_i != m_prev) && (m_mode == 0);
        old_mode = m_mode;
        if (tb_if.trace_ready_i && q.size() != 0) begin
            $display("pop  seq=%0d pc=%h inst=%h", q[0].seq, q[0].pc, q[0].inst);
            q.delete(0);
        end
        if (retire) begin
            if (q.size() < DEPTH) begin
                e.pc = pc_i; e.inst = inst_i; e.seq = nr_insts_i; e.cyc = m_cyc;
                q.push_back(e);
            end else if (m_dropped != 32'hFFFF_FFFF) begin
                m_dropped = m_dropped + 1;
            end
            if (nr_insts_i - m_prev > 64'd1) m_skip = 1'b1;
            if (inst_i == EBREAK_ENC) m_mode = 1;
        end
        if (old_mode == 1 && q.size() == 0) m_mode = 2;
        m_prev = nr_insts_i;
        m_cyc  = m_cyc + 1;
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        @(negedge clock);
        check_outputs();
    endtask

    task automatic retire_one(input logic [63:0] pc, input logic [31:0] inst);
        pc_i       = pc;
        inst_i     = inst;
        nr_insts_i = nr_insts_i + 64'd1;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        q.delete();
        m_prev = '0; m_mode = 0; m_dropped = '0; m_skip = 1'b0; m_cyc = '0;
        check_outputs();     // no clock edge yet: clearing must be asynchronous
        nr_insts_i = '0;
        @(negedge clock);
        reset = 1'b0;
        $display("reset released at %0t", $time);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tb_if.trace_ready_i = 1'b0;
        #1;
        do_reset();

        // Two back-to-back retirements with the consumer ready
        tb_if.trace_ready_i = 1'b1;
        retire_one(64'h8000_0000, 32'h0000_0013);
        check_val("t1_seq1", tb_if.trace_seq_o, 64'd1);
        retire_one(64'h8000_0004, 32'h0000_0093);
        check_val("t1_seq2", tb_if.trace_seq_o, 64'd2);
        tick();
        tick();
        check_val("t1_level0", 64'(level_o), 64'd0);

        // Overfill with the consumer stalled
        do_reset();
        tb_if.trace_ready_i = 1'b0;
        for (int i = 0; i < 20; i++) retire_one(64'h8000_1000 + 64'(4 * i), 32'h0010_0093 + 32'(i));
        check_val("fill_level",   64'(level_o), 64'd16);
        check_val("fill_dropped", 64'(dropped_o), 64'd4);
        check_val("fill_head",    tb_if.trace_seq_o, 64'd1);

        // Full, popping, and retiring in the same cycle
        tb_if.trace_ready_i = 1'b1;
        retire_one(64'h8000_2000, 32'h0000_0033);
        check_val("fullpop_level",   64'(level_o), 64'd16);
        check_val("fullpop_dropped", 64'(dropped_o), 64'd4);
        for (int i = 0; i < 15; i++) tick();
        check_val("drain_level1", 64'(level_o), 64'd1);
        tick();
        check_val("drain_level0", 64'(level_o), 64'd0);

        // Sequence number jump 5 -> 8
        do_reset();
        for (int i = 0; i < 5; i++) retire_one(64'h8000_3000 + 64'(4 * i), 32'h0000_0013);
        check_val("skip_before", 64'(skip_err_o), 64'd0);
        pc_i = 64'h8000_3100; inst_i = 32'h0000_0013; nr_insts_i = 64'd8;
        tick();
        check_val("skip_set",  64'(skip_err_o), 64'd1);
        check_val("skip_seq8", tb_if.trace_seq_o, 64'd8);
        retire_one(64'h8000_3104, 32'h0000_0013);
        check_val("skip_sticky", 64'(skip_err_o), 64'd1);

        // ebreak with three entries queued, later retirements ignored
        do_reset();
        tb_if.trace_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) retire_one(64'h8000_4000 + 64'(4 * i), 32'h0000_0013);
        tb_if.trace_ready_i = 1'b1;
        retire_one(64'h8000_400C, EBREAK_ENC);
        for (int i = 0; i < 4; i++) retire_one(64'h8000_4010 + 64'(4 * i), 32'h0000_0013);
        for (int i = 0; i < 40 && !halted_o; i++) tick();
        check_val("ebreak_halted", 64'(halted_o), 64'd1);
        check_val("ebreak_level",  64'(level_o), 64'd0);
        tick();
        check_val("ebreak_terminal", 64'(halted_o), 64'd1);

        // Reset while draining with five entries queued
        do_reset();
        tb_if.trace_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) retire_one(64'h8000_5000 + 64'(4 * i), 32'h0000_0013);
        retire_one(64'h8000_5010, EBREAK_ENC);
        check_val("middrain_level", 64'(level_o), 64'd5);
        do_reset();
        tb_if.trace_ready_i = 1'b1;
        retire_one(64'h8000_6000, 32'h0000_0013);
        check_val("post_reset_seq", tb_if.trace_seq_o, 64'd1);

        // Random traffic: bursty retirements, occasional skips, random back-pressure
        do_reset();
        for (int i = 0; i < 300; i++) begin
            int r;
            logic [31:0] ri;
            r  = int'($urandom_range(0, 99));
            ri = $urandom;
            if (ri == EBREAK_ENC) ri = ri ^ 32'h1;
            tb_if.trace_ready_i = ($urandom_range(0, 3) != 0);
            pc_i   = {$urandom, $urandom} & ~64'h3;
            inst_i = ri;
            if (r < 55)      nr_insts_i = nr_insts_i + 64'd1;
            else if (r < 58) nr_insts_i = nr_insts_i + 64'(2 + $urandom_range(0, 3));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Sits directly downstream of the CPU top level. Consumes the retirement view it exports: pc_o, inst_o and the monotonically increasing nr_insts_o.
- Detects each retirement and captures the (pc, inst, sequence number) tuple into a FIFO.
- Drains the FIFO to the Verilator host or difftest side over a valid/ready handshake.
- Detects ebreak retirement and sequences a clean halt: drain the FIFO, then assert halted.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- PTR_W, $clog2(DEPTH), pointer width; derived, never overridden.
- EBREAK, 32'h00100073, encoding that triggers the halt sequence.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- pc_i  in  64  retiring PC, from the top level's pc_o
- inst_i  in  32  retiring instruction, from the top level's inst_o
- nr_insts_i  in  64  retired-instruction count, from the top level's nr_insts_o
- trace_valid_o  out  1  head entry is valid
- trace_ready_i  in  1  consumer accepts the head entry
- trace_pc_o  out  64  head entry PC
- trace_inst_o  out  32  head entry instruction
- trace_seq_o  out  64  head entry sequence number (nr_insts value at capture)
- level_o  out  PTR_W+1  current occupancy
- dropped_o  out  32  retirements lost to a full FIFO; saturating
- skip_err_o  out  1  sticky: nr_insts advanced by more than 1 in one cycle
- halted_o  out  1  ebreak retired and FIFO fully drained

Behaviour:
- Reset values: FIFO empty, all outputs 0, prev_cnt = 0, state RUN.
- Retire detect: register prev_cnt <= nr_insts_i every cycle.
  - retire = (nr_insts_i != prev_cnt) and state == RUN.
  - delta = nr_insts_i - prev_cnt, modulo 2^64 (wrap from all-ones to 0 counts as delta 1).
  - delta > 1 sets skip_err_o; only one entry is still captured.
- Push: on retire, write {pc_i, inst_i, nr_insts_i} at the write pointer if not full. Capture latency is 1 cycle; the entry is visible on the trace outputs the cycle after the push if the FIFO was empty.
- Full: if full and no pop in the same cycle, the retirement is dropped; dropped_o increments, saturating at 32'hFFFF_FFFF.
- Full with simultaneous pop: the push succeeds; no drop is counted.
- Pop: occurs when trace_valid_o && trace_ready_i. trace_valid_o equals !empty. The head outputs hold stable while valid and not ready.
- Empty with simultaneous push: no bypass. The entry appears next cycle.
- Pointers: PTR_W bits plus one wrap bit each.
  - full = MSBs differ and LSBs equal.
  - level_o = wptr - rptr.
- State machine:
  - RUN: a captured retirement with inst_i == EBREAK goes to DRAIN. The ebreak entry itself is pushed; if it is dropped for lack of space, still go to DRAIN.
  - DRAIN: no new captures; prev_cnt keeps tracking. When empty, go to HALTED.
  - HALTED: halted_o = 1; terminal until reset.
- Reset mid-operation clears all state asynchronously; FIFO contents are discarded.

Optional Feature:
- Macro: TRACE_TIMESTAMP_EN.
- Defined:
  - Adds a free-running 64-bit cycle counter, reset 0 and wrapping.
  - Adds output port trace_cycle_o [63:0]; each entry stores the counter value at push.
  - Halt entry: the cycle count is captured like any other entry.
- Undefined: no counter, no port, FIFO entry width 160 bits.

Decomposition:
- Shared package trace_pkg holds:
  - the EBREAK constant;
  - the state enum TR_RUN/TR_DRAIN/TR_HALTED;
  - the entry width constant: 160, or 224 with TRACE_TIMESTAMP_EN.
- One sub-module, trace_fifo: parameterised storage plus pointers, push/pop/full/empty/level.
- The top module holds the retire detect, the state machine and the counters.

Test Plan:
- Reset, then nr_insts 0->1->2 with pc 0x80000000/0x80000004 and trace_ready_i=1 -> two entries appear, seq 1 and 2, one cycle after each push; level_o returns to 0.
- trace_ready_i=0, 20 retirements, DEPTH=16 -> level_o=16, dropped_o=4, the head stays seq 1; then ready=1 -> exactly 16 pops, in order.
- Full FIFO with ready=1 and a retirement in the same cycle -> push accepted, dropped_o unchanged, level_o stays 16.
- nr_insts jumps 5->8 -> skip_err_o=1 (sticky), one entry with seq 8 captured.
- Retire inst 0x00100073 with 3 entries queued, ready=1 -> later retirements ignored; halted_o=1 the cycle after the last pop.
- Assert reset mid-drain with level_o=5 -> outputs immediately 0, state RUN; the first retirement after release is captured normally.
